// File: rtl/reg_writeback_if.sv
// ----------------------------------------------------------------------------
// reg_writeback_if
//   Result handshake between the pipeline (producer) and the write-back unit.
//
//   Signals:
//     resValid  producer -> unit   result offered this cycle
//     resReady  unit -> producer   unit can accept a result (registered-only)
//     resReg    producer -> unit   destination register (already resolved)
//     resAlu    producer -> unit   ALU result
//     resMem    producer -> unit   load data
//     memToReg  producer -> unit   1 = write resMem, 0 = write resAlu
//
//   Modports:
//     master  the pipeline side that offers results
//     slave   the write-back unit that accepts them
// ----------------------------------------------------------------------------
interface reg_writeback_if;
   logic        resValid;
   logic        resReady;
   logic [4:0]  resReg;
   logic [31:0] resAlu;
   logic [31:0] resMem;
   logic        memToReg;

   modport master (
      output resValid, resReg, resAlu, resMem, memToReg,
      input  resReady
   );

   modport slave (
      input  resValid, resReg, resAlu, resMem, memToReg,
      output resReady
   );
endinterface

// File: rtl/reg_writeback.sv
// ----------------------------------------------------------------------------
// reg_writeback
//   Write-back unit for the MIPS core. Accepts ALU/load results through a
//   valid/ready handshake, buffers them in a DEPTH-entry FIFO and drains at
//   most one register-file write per cycle. Maintains a 32-bit pending-write
//   scoreboard for decode hazard detection.
//
//   Optional feature macro: REG_WB_BYPASS_EN
//     When defined, adds a combinational bypass search (qReg -> qHit/qData)
//     over the queued entries and the registered output stage.
//
//   Ports:
//     clk         single clock, rising edge
//     rst_n       asynchronous active-low reset
//     res_if      result handshake (slave side)
//     issueValid  decode reserves destination issueReg this cycle
//     issueReg    destination being reserved
//     wrStall     register-file write port unavailable this cycle
//     regWrite    register-file write enable (registered)
//     writeReg    register-file write address (registered)
//     writeData   register-file write data (registered)
//     busy        scoreboard, bit r = write to register r outstanding
//     qReg        bypass query address           (REG_WB_BYPASS_EN only)
//     qHit        queued write to qReg exists    (REG_WB_BYPASS_EN only)
//     qData       data of youngest write to qReg (REG_WB_BYPASS_EN only)
// ----------------------------------------------------------------------------
module reg_writeback #(
   parameter int DEPTH = 4
) (
   input  logic          clk,
   input  logic          rst_n,
   reg_writeback_if.slave res_if,
   input  logic          issueValid,
   input  logic [4:0]    issueReg,
   input  logic          wrStall,
   output logic          regWrite,
   output logic [4:0]    writeReg,
   output logic [31:0]   writeData,
   output logic [31:0]   busy
`ifdef REG_WB_BYPASS_EN
   ,
   input  logic [4:0]    qReg,
   output logic          qHit,
   output logic [31:0]   qData
`endif
);

   localparam int AW = $clog2(DEPTH);

   // Pointers carry one extra wrap bit so full and empty are distinguishable.
   logic [AW:0]  r_wr_ptr;
   logic [AW:0]  r_rd_ptr;
   logic [4:0]   r_q_reg  [DEPTH];
   logic [31:0]  r_q_data [DEPTH];

   logic         r_reg_write;
   logic [4:0]   r_write_reg;
   logic [31:0]  r_write_data;
   logic [31:0]  r_busy;

   logic         w_full;
   logic         w_empty;
   logic         w_accept;
   logic         w_push;
   logic         w_pop;
   logic [31:0]  w_wr_data;
   logic [AW-1:0] w_head;
   logic [31:0]  w_busy_set;
   logic [31:0]  w_busy_clr;

   assign w_empty = (r_wr_ptr == r_rd_ptr);
   assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                    (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);

   // Ready is a pure function of the pointers: no path from wrStall/resValid.
   assign res_if.resReady = !w_full;

   assign w_accept  = res_if.resValid && !w_full;
   // Writes to $zero complete the handshake but never enter the queue.
   assign w_push    = w_accept && (res_if.resReg != 5'd0);
   assign w_pop     = !w_empty && !wrStall;
   assign w_wr_data = res_if.memToReg ? res_if.resMem : res_if.resAlu;
   assign w_head    = r_rd_ptr[AW-1:0];

   // NOTE: sequential state is updated with non-blocking assignments so every
   // register samples the pre-edge values of its sources.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      end
   end

   // NOTE: the storage array is deliberately not reset; the pointers alone
   // decide which entries are valid, so stale contents are never observed.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_q_reg[r_wr_ptr[AW-1:0]]  <= res_if.resReg;
         r_q_data[r_wr_ptr[AW-1:0]] <= w_wr_data;
      end
   end

   // Output stage: address/data hold their last values when nothing pops.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_reg_write  <= 1'b0;
         r_write_reg  <= 5'd0;
         r_write_data <= 32'd0;
      end else begin
         r_reg_write <= w_pop;
         if (w_pop) begin
            r_write_reg  <= r_q_reg[w_head];
            r_write_data <= r_q_data[w_head];
         end
      end
   end

   // NOTE: every signal written in a combinational block gets a default
   // first, so no path leaves it unassigned and no latch is inferred.
   always_comb begin
      w_busy_set = '0;
      w_busy_clr = '0;
      if (issueValid) w_busy_set[issueReg] = 1'b1;
      if (w_pop)      w_busy_clr[r_q_reg[w_head]] = 1'b1;
   end

   // Set wins over clear on the same edge; bit 0 is forced low.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_busy <= '0;
      end else begin
         r_busy <= ((r_busy & ~w_busy_clr) | w_busy_set) & ~32'd1;
      end
   end

   assign regWrite  = r_reg_write;
   assign writeReg  = r_write_reg;
   assign writeData = r_write_data;
   assign busy      = r_busy;

`ifdef REG_WB_BYPASS_EN
   logic [AW:0]   w_count;
   logic          w_q_hit;
   logic [31:0]   w_q_data;

   assign w_count = r_wr_ptr - r_rd_ptr;

   // Scan oldest to youngest (output stage first, then queue from head) so
   // the last match found is the youngest write.
   always_comb begin
      w_q_hit  = 1'b0;
      w_q_data = 32'd0;
      if (r_reg_write && (r_write_reg == qReg)) begin
         w_q_hit  = 1'b1;
         w_q_data = r_write_data;
      end
      for (int i = 0; i < DEPTH; i++) begin
         if (((AW+1)'(i) < w_count) &&
             (r_q_reg[r_rd_ptr[AW-1:0] + AW'(i)] == qReg)) begin
            w_q_hit  = 1'b1;
            w_q_data = r_q_data[r_rd_ptr[AW-1:0] + AW'(i)];
         end
      end
      if (qReg == 5'd0) begin
         w_q_hit  = 1'b0;
         w_q_data = 32'd0;
      end
   end

   assign qHit  = w_q_hit;
   assign qData = w_q_data;
`endif

endmodule

// File: tb/tb_reg_writeback.sv
// ----------------------------------------------------------------------------
// tb_reg_writeback
//   Directed self-checking bench for reg_writeback (DEPTH = 4). Inputs change
//   1 ns after a rising edge; outputs are sampled at that same point.
// ----------------------------------------------------------------------------
module tb_reg_writeback;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        issueValid;
   logic [4:0]  issueReg;
   logic        wrStall;
   logic        regWrite;
   logic [4:0]  writeReg;
   logic [31:0] writeData;
   logic [31:0] busy;
`ifdef REG_WB_BYPASS_EN
   logic [4:0]  qReg;
   logic        qHit;
   logic [31:0] qData;
`endif

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   reg_writeback_if res_if ();

   reg_writeback #(.DEPTH(4)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .res_if     (res_if),
      .issueValid (issueValid),
      .issueReg   (issueReg),
      .wrStall    (wrStall),
      .regWrite   (regWrite),
      .writeReg   (writeReg),
      .writeData  (writeData),
      .busy       (busy)
`ifdef REG_WB_BYPASS_EN
      ,
      .qReg       (qReg),
      .qHit       (qHit),
      .qData      (qData)
`endif
   );

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic offer(input logic [4:0] r, input logic [31:0] alu,
                        input logic [31:0] mem, input logic m2r);
      res_if.resValid = 1'b1;
      res_if.resReg   = r;
      res_if.resAlu   = alu;
      res_if.resMem   = mem;
      res_if.memToReg = m2r;
   endtask

   initial begin
      rst_n           = 1'b0;
      issueValid      = 1'b0;
      issueReg        = 5'd0;
      wrStall         = 1'b0;
      res_if.resValid = 1'b0;
      res_if.resReg   = 5'd0;
      res_if.resAlu   = 32'd0;
      res_if.resMem   = 32'd0;
      res_if.memToReg = 1'b0;
`ifdef REG_WB_BYPASS_EN
      qReg            = 5'd0;
`endif

      // Reset state
      #12;
      check("rst_regWrite",  {31'd0, regWrite}, 32'd0);
      check("rst_writeReg",  {27'd0, writeReg}, 32'd0);
      check("rst_writeData", writeData, 32'd0);
      check("rst_busy",      busy, 32'd0);
      check("rst_resReady",  {31'd0, res_if.resReady}, 32'd1);
      #10 rst_n = 1'b1;
      tick();

      // Basic issue / accept / write-back
      issueValid = 1'b1; issueReg = 5'd8;
      tick();
      issueValid = 1'b0;
      check("issue8_busy", busy, 32'h0000_0100);
      offer(5'd8, 32'h1234, 32'h5555, 1'b0);
      tick();                                   // accept edge k
      res_if.resValid = 1'b0;
      check("acc8_noWrite", {31'd0, regWrite}, 32'd0);
      check("acc8_busy",    busy, 32'h0000_0100);
      tick();                                   // pop edge k+1
      check("wb8_regWrite",  {31'd0, regWrite}, 32'd1);
      check("wb8_writeReg",  {27'd0, writeReg}, 32'd8);
      check("wb8_writeData", writeData, 32'h0000_1234);
      check("wb8_busy",      busy, 32'd0);
      tick();
      check("wb8_idle", {31'd0, regWrite}, 32'd0);
      check("wb8_hold", {27'd0, writeReg}, 32'd8);

      // Fill under stall: 5 offered, 4 accepted
      wrStall = 1'b1;
      for (int i = 0; i < 5; i++) begin
         offer(5'(i + 1), 32'h100 + 32'(i + 1), 32'd0, 1'b0);
         check($sformatf("fill_ready%0d", i), {31'd0, res_if.resReady},
               (i < 4) ? 32'd1 : 32'd0);
         tick();
      end
      res_if.resValid = 1'b0;
      check("full_ready",    {31'd0, res_if.resReady}, 32'd0);
      check("stall_noWrite", {31'd0, regWrite}, 32'd0);
      check("stall_holdReg", {27'd0, writeReg}, 32'd8);
      check("stall_holdDat", writeData, 32'h0000_1234);
      wrStall = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tick();
         check($sformatf("drain%0d_we", i),   {31'd0, regWrite}, 32'd1);
         check($sformatf("drain%0d_reg", i),  {27'd0, writeReg}, 32'(i + 1));
         check($sformatf("drain%0d_data", i), writeData, 32'h101 + 32'(i));
         check($sformatf("drain%0d_rdy", i),  {31'd0, res_if.resReady}, 32'd1);
      end
      tick();
      check("drain_done", {31'd0, regWrite}, 32'd0);

      // Result to register 0 is swallowed
      offer(5'd0, 32'hFFFF_FFFF, 32'd0, 1'b0);
      check("r0_ready", {31'd0, res_if.resReady}, 32'd1);
      tick();
      res_if.resValid = 1'b0;
      tick();
      check("r0_noWrite", {31'd0, regWrite}, 32'd0);
      tick();
      check("r0_noWrite2", {31'd0, regWrite}, 32'd0);
      check("r0_busy",     busy, 32'd0);
      check("r0_holdData", writeData, 32'h0000_0104);

      // Load data, re-issue on accept edge, set beats clear on pop edge
      issueValid = 1'b1; issueReg = 5'd9;
      tick();
      check("issue9_busy", busy, 32'h0000_0200);
      offer(5'd9, 32'h1111, 32'hDEAD_BEEF, 1'b1);
      tick();                                   // accept + issue same edge
      res_if.resValid = 1'b0;
      check("acc9_busy", busy, 32'h0000_0200);
      tick();                                   // pop edge, issue 9 again
      issueValid = 1'b0;
      check("wb9_regWrite",  {31'd0, regWrite}, 32'd1);
      check("wb9_writeReg",  {27'd0, writeReg}, 32'd9);
      check("wb9_writeData", writeData, 32'hDEAD_BEEF);
      check("wb9_busy",      busy, 32'h0000_0200);

      // Asynchronous reset with entries queued
      wrStall = 1'b1;
      for (int i = 0; i < 4; i++) begin
         issueValid = 1'b1; issueReg = 5'(10 + i);
         offer(5'(10 + i), 32'hA0 + 32'(i), 32'd0, 1'b0);
         tick();
      end
      issueValid      = 1'b0;
      res_if.resValid = 1'b0;
      wrStall         = 1'b0;
      tick();                                   // pop reg 10, 3 left
      wrStall = 1'b1;
      check("pre_rst_we",   {31'd0, regWrite}, 32'd1);
      check("pre_rst_reg",  {27'd0, writeReg}, 32'd10);
      check("pre_rst_busy", busy, 32'h0000_3A00);
      #2 rst_n = 1'b0;
      #1;
      check("arst_regWrite",  {31'd0, regWrite}, 32'd0);
      check("arst_busy",      busy, 32'd0);
      check("arst_ready",     {31'd0, res_if.resReady}, 32'd1);
      check("arst_writeReg",  {27'd0, writeReg}, 32'd0);
      check("arst_writeData", writeData, 32'd0);
      #10 rst_n = 1'b1;
      wrStall = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         check($sformatf("post_rst_idle%0d", i), {31'd0, regWrite}, 32'd0);
      end
      offer(5'd7, 32'h77, 32'd0, 1'b0);
      tick();
      res_if.resValid = 1'b0;
      check("post_rst_acc", {31'd0, regWrite}, 32'd0);
      tick();
      check("post_rst_we",   {31'd0, regWrite}, 32'd1);
      check("post_rst_reg",  {27'd0, writeReg}, 32'd7);
      check("post_rst_data", writeData, 32'h0000_0077);

`ifdef REG_WB_BYPASS_EN
      // Bypass search: youngest queued match wins
      tick();
      wrStall = 1'b1;
      qReg    = 5'd5;
      offer(5'd5, 32'hA, 32'd0, 1'b0);
      tick();
      check("byp_hitA",  {31'd0, qHit}, 32'd1);
      check("byp_dataA", qData, 32'h0000_000A);
      offer(5'd5, 32'hB, 32'd0, 1'b0);
      tick();
      res_if.resValid = 1'b0;
      check("byp_hitB",  {31'd0, qHit}, 32'd1);
      check("byp_dataB", qData, 32'h0000_000B);
      qReg = 5'd0;
      #1;
      check("byp_r0", {31'd0, qHit}, 32'd0);
      qReg = 5'd6;
      #1;
      check("byp_miss", {31'd0, qHit}, 32'd0);
      qReg    = 5'd5;
      wrStall = 1'b0;
      tick();
      tick();
      check("byp_out_we",   {31'd0, regWrite}, 32'd1);
      check("byp_out_hit",  {31'd0, qHit}, 32'd1);
      check("byp_out_data", qData, 32'h0000_000B);
      tick();
      check("byp_gone", {31'd0, qHit}, 32'd0);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/reg_writeback.md
# reg_writeback

Write-back unit for the MIPS core: the producer that drives the register file's write port. It accepts ALU and load results from the pipeline through a valid/ready handshake and buffers them in a small FIFO. It drains at most one write per cycle onto the register file's regWrite/writeReg/writeData inputs and keeps a 32-bit pending-write scoreboard that decode uses for hazard detection.

## Interface
- DEPTH, 4, result FIFO entries; power of two, 2..16.

- clk  in  1  single clock; all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- issueValid  in  1  decode reserves a destination register this cycle
- issueReg  in  5  destination being reserved
- resValid  in  1  result offered by the pipeline
- resReady  out  1  unit can accept a result; equals !full
- resReg  in  5  destination of the offered result (already resolved rd/rt/31)
- resAlu  in  32  ALU result
- resMem  in  32  load data
- memToReg  in  1  1 = write resMem, 0 = write resAlu
- wrStall  in  1  register file write port unavailable this cycle
- regWrite  out  1  register-file write enable (registered)
- writeReg  out  5  register-file write address (registered)
- writeData  out  32  register-file write data (registered)
- busy  out  32  scoreboard; bit r = write to register r outstanding
- qReg  in  5  bypass query address (only with REG_WB_BYPASS_EN)
- qHit  out  1  queued write to qReg exists (only with REG_WB_BYPASS_EN)
- qData  out  32  data of the youngest queued write to qReg (only with REG_WB_BYPASS_EN)

## Operation
- Enqueue: on an edge with resValid && resReady, select data = memToReg ? resMem : resAlu and push {resReg, data} into the FIFO.
- Results with resReg == 0 complete the handshake but are discarded: no push and no scoreboard change.
- Drain: at each edge, if the FIFO is not empty and wrStall == 0, pop the head. The popped entry drives regWrite=1, writeReg and writeData for the following cycle. Otherwise regWrite=0, and writeReg/writeData hold their last values.
- Order: writes leave in acceptance order. No merging, no reordering.
- Scoreboard:
  - An edge with issueValid && issueReg != 0 sets busy[issueReg].
  - The pop of an entry clears busy[entry.reg].
  - Set and clear of the same bit on the same edge: set wins.
  - busy[0] is constantly 0.
- Decode must not issue to a register whose busy bit is set (no WAW tracking). If it does, the bit clears on the first pop to that register.
- Full: resReady=0, and resValid is ignored. A pop and a push on the same edge are legal when not full. resReady depends only on registered state, with no combinational path from wrStall or resValid.
- Pointers are log2(DEPTH) bits plus one wrap bit. full/empty are derived from pointer equality and the wrap bit.

## Timing
- Reset (rst_n low, asynchronous):
  - FIFO empty
  - regWrite=0, writeReg=0, writeData=0
  - busy=0
  - resReady=1 (and stays 1 while rst_n is low)
  - qHit=0
- Reset mid-operation discards all queued results and clears all busy bits. The first accept is possible on the first edge after rst_n rises.
- Latency: result accepted at edge k into an empty FIFO with wrStall=0 → popped at edge k+1 → regWrite=1 during the cycle after edge k+1.
- Throughput: one accept and one write per cycle sustained.
- wrStall asserted for n cycles delays the head by n cycles and loses nothing.

## Configuration
- REG_WB_BYPASS_EN defined:
  - qHit/qData are live and combinational.
  - The search covers the queued entries plus the registered output stage while regWrite=1.
  - The youngest match wins.
  - qReg == 0 always gives qHit=0.
- REG_WB_BYPASS_EN undefined: the qReg/qHit/qData ports are absent and no search logic is built.

## Test plan
- Reset, then issue reg 8, then accept {8, resAlu=0x1234} with memToReg=0 → busy[8]=1 after issue; regWrite=1, writeReg=8, writeData=0x00001234 two cycles after accept; busy[8]=0 after the pop edge.
- Hold wrStall=1 and offer 5 results with DEPTH=4 → exactly 4 accepted, resReady=0. Release wrStall → 4 writes on consecutive cycles in order, then resReady=1.
- Accept {0, 0xFFFFFFFF} → handshake completes, regWrite stays 0, busy unchanged.
- Accept {9, resMem=0xDEADBEEF, memToReg=1} on the same edge that issueValid sets reg 9 again → writeData=0xDEADBEEF, and busy[9] remains 1 after the pop.
- Assert rst_n=0 asynchronously with 3 entries queued → regWrite drops immediately, busy=0, and no writes after release.
- With REG_WB_BYPASS_EN: queue {5, 0xA}, then {5, 0xB}, with wrStall=1 and qReg=5 → qHit=1, qData=0xB. With qReg=0 → qHit=0.
